// File: rtl/fpg8_loader_pkg.sv
// Shared types for the FPG8 serial loader: loader/receiver state encodings
// and the word-count rule (a count byte of 0 stands for a full 256-word image).
package fpg8_loader_pkg;

  typedef enum logic [2:0] {IDLE, HI, LO, WR, CHK, DONE, ERR} state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int COUNT_WIDTH = 9;

  function automatic logic [COUNT_WIDTH-1:0] decode_count(input logic [7:0] n);
    return (n == 8'd0) ? COUNT_WIDTH'(256) : COUNT_WIDTH'(n);
  endfunction

endpackage

// File: rtl/fpg8_serial_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop sync, mid-bit sampling, one-cycle byte_valid/byte_err.
// Latency ~9.5 bit times + 2 cycles from start edge; no backpressure, bytes must be consumed on arrival.
module uart_rx_byte
  import fpg8_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  rx_state_t       st;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) st <= RX_START;
        end
        // A line that is high again at mid-start was only a glitch.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              data       <= shreg;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fpg8_serial_loader.sv
// Loads a count/words/checksum image from UART into the core RAM, holding the core in reset meanwhile.
// Write strobe 1 cycle after the low byte; done/hold change 1 cycle after the checksum byte; no backpressure.
module fpg8_serial_loader
  import fpg8_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_w_en,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  logic                   byte_valid;
  logic                   byte_err;
  logic [7:0]             rx_data;
  state_t                 state;
  logic [COUNT_WIDTH-1:0] count_rem;
  logic [7:0]             checksum;
  logic [7:0]             hi_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .data      (rx_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count_rem <= '0;
      checksum  <= '0;
      hi_byte   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_w_en  <= 1'b0;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      ram_w_en <= 1'b0;
      if (byte_err && state != DONE && state != ERR) begin
        state    <= ERR;
        load_err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (byte_valid) begin
            count_rem <= decode_count(rx_data);
            checksum  <= '0;
            ram_addr  <= '0;
            state     <= HI;
          end
          HI: if (byte_valid) begin
            hi_byte  <= rx_data;
            checksum <= checksum + rx_data;
            state    <= LO;
          end
          // Data and strobe are registered here so they are valid during WR.
          LO: if (byte_valid) begin
            checksum  <= checksum + rx_data;
            ram_wdata <= DATA_WIDTH'({hi_byte, rx_data});
            ram_w_en  <= 1'b1;
            state     <= WR;
          end
          WR: begin
            ram_addr  <= ram_addr + ADDR_WIDTH'(1);
            count_rem <= count_rem - COUNT_WIDTH'(1);
            state     <= (count_rem == COUNT_WIDTH'(1)) ? CHK : HI;
          end
          CHK: if (byte_valid) begin
            if (rx_data == checksum) begin
              state     <= DONE;
              core_hold <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
          DONE: state <= DONE;
          ERR:  state <= ERR;
          default: state <= ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpg8_serial_loader.sv
// Self-checking bench: directed and random images over the UART line, checked
// against a write list and checksum derived from the stream format.
module tb_fpg8_serial_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_w_en;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int passed = 0;

  logic [23:0] wq[$];
  logic [15:0] img[256];

  always #5 clk = ~clk;

  fpg8_serial_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_w_en (ram_w_en),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always @(negedge clk) if (ram_w_en) wq.push_back({ram_addr, ram_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] model_csum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s = s + int'(img[i][15:8]) + int'(img[i][7:0]);
    return 8'(s % 256);
  endfunction

  task automatic send_image(input int n, input logic [7:0] csum_delta, input bit gaps);
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], 1'b1);
      if (gaps) idle($urandom_range(0, 2));
      send_byte(img[i][7:0], 1'b1);
      if (gaps) idle($urandom_range(0, 2));
    end
    send_byte(model_csum(n) + csum_delta, 1'b1);
    idle(4 * CPB);
  endtask

  task automatic do_reset(input string tag);
    rx    = 1'b1;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    wq.delete();
    check({tag, "_rst_addr"},  32'(ram_addr),  32'h0);
    check({tag, "_rst_wdata"}, 32'(ram_wdata), 32'h0);
    check({tag, "_rst_wen"},   32'(ram_w_en),  32'h0);
    check({tag, "_rst_hold"},  32'(core_hold), 32'h1);
    check({tag, "_rst_done"},  32'(load_done), 32'h0);
    check({tag, "_rst_err"},   32'(load_err),  32'h0);
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwrites"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++)
      check({tag, "_write"}, 32'(wq[i]), 32'({8'(i), img[i]}));
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"},  32'(load_err),  32'(err));
    check({tag, "_hold"}, 32'(core_hold), 32'(!done));
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b1;

    // Basic two-word image.
    do_reset("init");
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    send_image(2, 8'd0, 1'b0);
    check_writes("two_ok", 2);
    check("two_ok_addr", 32'(ram_addr), 32'd2);
    check_status("two_ok", 1'b1, 1'b0);

    // Same image, checksum off by one.
    do_reset("bad");
    send_image(2, 8'd1, 1'b0);
    check_writes("two_bad", 2);
    check_status("two_bad", 1'b0, 1'b1);

    // Count byte 0: full 256-word image, address wraps to 0.
    do_reset("full");
    for (int i = 0; i < 256; i++) img[i] = 16'(i);
    send_image(256, 8'd0, 1'b0);
    check_writes("full", 256);
    check("full_addr", 32'(ram_addr), 32'h0);
    check_status("full", 1'b1, 1'b0);

    // Framing error on the second data byte; the rest of the stream is ignored.
    do_reset("frame");
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    idle(4 * CPB);
    check("frame_nwrites", 32'(wq.size()), 32'd0);
    check_status("frame", 1'b0, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(4 * CPB);
    check("frame_after_nwrites", 32'(wq.size()), 32'd0);
    check_status("frame_after", 1'b0, 1'b1);

    // One-cycle low glitch while idle, then a valid one-word image.
    do_reset("glitch");
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(4 * CPB);
    img[0] = 16'h00FF;
    check("glitch_csum_model", 32'(model_csum(1)), 32'hFF);
    send_image(1, 8'd0, 1'b0);
    check_writes("glitch", 1);
    check_status("glitch", 1'b1, 1'b0);

    // Reset in the middle of a two-word image, then a fresh one-word load.
    do_reset("mid");
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(2);
    check("mid_partial_nwrites", 32'(wq.size()), 32'd1);
    do_reset("mid2");
    img[0] = 16'h5A5A;
    check("mid_csum_model", 32'(model_csum(1)), 32'hB4);
    send_image(1, 8'd0, 1'b0);
    check_writes("mid", 1);
    check_status("mid", 1'b1, 1'b0);

    // Random images with random inter-byte gaps and occasional bad checksums.
    for (int r = 0; r < 6; r++) begin
      int         n;
      bit         bad;
      logic [7:0] delta;
      do_reset("rnd");
      n     = $urandom_range(1, 12);
      bad   = ($urandom_range(0, 2) == 0);
      delta = bad ? 8'($urandom_range(1, 255)) : 8'd0;
      for (int i = 0; i < n; i++) img[i] = 16'($urandom);
      send_image(n, delta, 1'b1);
      check_writes("rnd", n);
      check_status("rnd", !bad, bad);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
